// File: rtl/uart_rx_frame_sequencer.sv
// UART receive frame sequencer: walks START/DATA/PARITY/STOP fields
// with its own oversampling edge counter and per-frame config shadows.
module uart_rx_frame_sequencer #(
    parameter int MAX_DATA_BITS = 8,
    parameter int PRESCALE_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            data_bits,
    input  logic                  par_en,
    input  logic                  stop2,
    output logic [2:0]            field,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [3:0]            bit_count,
    output logic [3:0]            bit_index,
    output logic                  sample_win,
    output logic                  bit_tick,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        F_IDLE   = 3'd0,
        F_START  = 3'd1,
        F_DATA   = 3'd2,
        F_PARITY = 3'd3,
        F_STOP1  = 3'd4,
        F_STOP2  = 3'd5
    } field_e;

    localparam logic [3:0] MAX_DB = 4'(MAX_DATA_BITS);
    localparam logic [3:0] DEF_DB = (MAX_DATA_BITS < 8) ? MAX_DB : 4'd8;
    localparam logic [PRESCALE_W-1:0] MIN_PS = PRESCALE_W'(4);
    localparam logic [PRESCALE_W-1:0] DEF_PS = PRESCALE_W'(16);

    field_e                r_field;
    logic [PRESCALE_W-1:0] r_edge;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            r_bit_idx;
    logic [PRESCALE_W-1:0] r_ps_q;
    logic [3:0]            r_db_q;
    logic                  r_par_q;
    logic                  r_stop2_q;

    logic                  w_active;
    logic                  w_tick;
    logic                  w_last;
    logic                  w_done;
    logic                  w_load;
    logic [PRESCALE_W-1:0] w_mid;
    logic [PRESCALE_W-1:0] w_ps_clamp;
    logic [3:0]            w_db_clamp;

    assign w_active = (r_field != F_IDLE);
    assign w_tick   = en && w_active &&
                      (r_edge == r_ps_q - PRESCALE_W'(1));
    assign w_last   = (r_field == F_STOP2) ||
                      ((r_field == F_STOP1) && !r_stop2_q);
    assign w_done   = w_tick && w_last;
    assign w_load   = !w_active || w_done;
    assign w_mid    = r_ps_q >> 1;

    assign w_ps_clamp = (prescale < MIN_PS) ? MIN_PS : prescale;
    assign w_db_clamp = (data_bits < 4'd5)  ? 4'd5 :
                        (data_bits > MAX_DB) ? MAX_DB : data_bits;

    assign field      = r_field;
    assign edge_count = r_edge;
    assign bit_count  = r_bit_cnt;
    assign bit_index  = r_bit_idx;
    assign bit_tick   = w_tick;
    assign frame_done = w_done;
    assign sample_win = w_active &&
                        (r_edge >= w_mid - PRESCALE_W'(1)) &&
                        (r_edge <= w_mid + PRESCALE_W'(1));

    // Capture clamped config between frames; held steady mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ps_q    <= DEF_PS;
            r_db_q    <= DEF_DB;
            r_par_q   <= 1'b0;
            r_stop2_q <= 1'b0;
        end else if (w_load) begin
            r_ps_q    <= w_ps_clamp;
            r_db_q    <= w_db_clamp;
            r_par_q   <= par_en;
            r_stop2_q <= stop2;
        end
    end

    // Field state machine with edge, bit and data-index counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_field   <= F_IDLE;
            r_edge    <= '0;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
        end else if (!en) begin
            r_field   <= F_IDLE;
            r_edge    <= '0;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
        end else if (!w_active) begin
            r_field   <= F_START;
            r_edge    <= '0;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
        end else if (w_tick) begin
            r_edge <= '0;
            if (w_last) begin
                r_field   <= F_START;
                r_bit_cnt <= '0;
                r_bit_idx <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                unique case (r_field)
                    F_START: begin
                        r_field   <= F_DATA;
                        r_bit_idx <= '0;
                    end
                    F_DATA: begin
                        if (r_bit_idx < r_db_q - 4'd1) begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end else begin
                            r_bit_idx <= '0;
                            r_field   <= r_par_q ? F_PARITY : F_STOP1;
                        end
                    end
                    F_PARITY: r_field <= F_STOP1;
                    F_STOP1:  r_field <= F_STOP2;
                    default: begin
                        r_field   <= F_IDLE;
                        r_bit_idx <= '0;
                    end
                endcase
            end
        end else begin
            r_edge <= r_edge + PRESCALE_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_sequencer.sv
// Directed bench for uart_rx_frame_sequencer: frame formats, config
// shadowing, abort, async reset and clamping.
module tb_uart_rx_frame_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [5:0] prescale;
    logic [3:0] data_bits;
    logic       par_en;
    logic       stop2;
    logic [2:0] field;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic [3:0] bit_index;
    logic       sample_win;
    logic       bit_tick;
    logic       frame_done;

    int n_chk;
    int n_err;

    uart_rx_frame_sequencer #(
        .MAX_DATA_BITS(8),
        .PRESCALE_W(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .prescale(prescale),
        .data_bits(data_bits),
        .par_en(par_en),
        .stop2(stop2),
        .field(field),
        .edge_count(edge_count),
        .bit_count(bit_count),
        .bit_index(bit_index),
        .sample_win(sample_win),
        .bit_tick(bit_tick),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int db, input int pa, input int s2,
                           input int ps);
        data_bits = 4'(db);
        par_en    = pa[0];
        stop2     = s2[0];
        prescale  = 6'(ps);
    endtask

    // Walks one frame from its START cycle, checking each cycle
    // against field/edge positions derived from the cycle number.
    task automatic run_frame(
        input  string tag,
        input  int db, input int pa, input int s2, input int ps,
        input  int ap,
        input  int ndb, input int npa, input int ns2, input int nps,
        input  int drop,
        output int done_at, output int max_bc, output int max_bi,
        output int mask
    );
        int n, len, b, e, ef, ei, et, ed, bad, first;
        bit stop;
        n = 1 + db + pa + 1 + s2;
        len = n * ps;
        bad = 0; first = -1; stop = 0;
        done_at = 0; max_bc = 0; max_bi = 0; mask = 0;
        for (int c = 0; c < len && !stop; c++) begin
            if (c == ap) set_cfg(ndb, npa, ns2, nps);
            if (c == drop) en = 1'b0;
            #1;
            b = c / ps;
            e = c % ps;
            if (b == 0)                   ef = 1;
            else if (b <= db)             ef = 2;
            else if (pa && b == db + 1)   ef = 3;
            else if (b == db + 1 + pa)    ef = 4;
            else                          ef = 5;
            ei = (ef == 2) ? b - 1 : 0;
            et = (e == ps - 1 && c != drop) ? 1 : 0;
            ed = (et == 1 && b == n - 1) ? 1 : 0;
            if (int'(field) != ef || int'(edge_count) != e ||
                int'(bit_count) != b || int'(bit_index) != ei ||
                int'(bit_tick) != et || int'(frame_done) != ed) begin
                bad++;
                if (first < 0) first = c;
            end
            if (frame_done && done_at == 0) done_at = c + 1;
            if (sample_win) mask |= (1 << edge_count);
            if (int'(bit_count) > max_bc) max_bc = int'(bit_count);
            if (int'(bit_index) > max_bi) max_bi = int'(bit_index);
            if (c == drop) stop = 1;
            @(posedge clk);
            #1;
        end
        chk({tag, "_seq_bad"}, bad, 0);
        if (bad != 0) $display("  %s first bad cycle %0d", tag, first);
    endtask

    int done_at, max_bc, max_bi, mask;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b0;
        en = 1'b0;
        set_cfg(8, 0, 0, 8);
        #12;
        chk("rst_field", field, 0);
        chk("rst_edge", edge_count, 0);
        chk("rst_bitcnt", bit_count, 0);
        chk("rst_bitidx", bit_index, 0);
        chk("rst_win", sample_win, 0);
        chk("rst_tick", bit_tick, 0);
        chk("rst_done", frame_done, 0);

        // Start an 8N1/8x frame, then hit async reset mid-DATA.
        rst = 1'b1;
        step();
        en = 1'b1;
        step();
        chk("pre_start_field", field, 1);
        repeat (20) step();
        chk("pre_mid_field", field, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("async_field", field, 0);
        chk("async_edge", edge_count, 0);
        chk("async_bitcnt", bit_count, 0);
        chk("async_bitidx", bit_index, 0);
        chk("async_win", sample_win, 0);
        set_cfg(8, 0, 0, 16);
        step();
        #2;
        rst = 1'b1;
        step();
        chk("rel_start_field", field, 1);
        chk("rel_start_edge", edge_count, 0);

        // Default 8N1 at 16x; next frame config staged mid-frame.
        run_frame("dflt", 8, 0, 0, 16, 1, 8, 0, 0, 8, -1,
                  done_at, max_bc, max_bi, mask);
        chk("dflt_done_at", done_at, 160);
        chk("dflt_max_bc", max_bc, 9);

        run_frame("f8n1", 8, 0, 0, 8, 1, 7, 1, 1, 16, -1,
                  done_at, max_bc, max_bi, mask);
        chk("f8n1_done_at", done_at, 80);
        chk("f8n1_max_bc", max_bc, 9);
        chk("f8n1_max_bi", max_bi, 7);
        chk("f8n1_win_mask", mask, 32'h38);

        run_frame("f7e2", 7, 1, 1, 16, 1, 8, 0, 0, 16, -1,
                  done_at, max_bc, max_bi, mask);
        chk("f7e2_done_at", done_at, 176);
        chk("f7e2_max_bc", max_bc, 10);
        chk("f7e2_max_bi", max_bi, 6);
        chk("f7e2_win_mask", mask, 32'h380);

        // Config change during DATA must not affect this frame.
        run_frame("shadow", 8, 0, 0, 16, 48, 5, 0, 0, 8, -1,
                  done_at, max_bc, max_bi, mask);
        chk("shadow_done_at", done_at, 160);

        // Back-to-back 5N1/8x frame, aborted at DATA bit 3 edge 5.
        run_frame("abort", 5, 0, 0, 8, 37, 3, 0, 0, 2, 37,
                  done_at, max_bc, max_bi, mask);
        chk("abort_no_done", done_at, 0);
        chk("abort_field", field, 0);
        chk("abort_edge", edge_count, 0);
        chk("abort_bitcnt", bit_count, 0);
        chk("abort_bitidx", bit_index, 0);
        chk("abort_win", sample_win, 0);
        step();
        en = 1'b1;
        step();
        chk("restart_field", field, 1);
        chk("restart_edge", edge_count, 0);

        // data_bits=3, prescale=2 clamp to 5 bits at 4x.
        run_frame("clamp", 5, 0, 0, 4, -1, 0, 0, 0, 0, -1,
                  done_at, max_bc, max_bi, mask);
        chk("clamp_done_at", done_at, 28);
        chk("clamp_max_bc", max_bc, 6);
        chk("clamp_max_bi", max_bi, 4);
        chk("clamp_win_mask", mask, 32'hE);

        en = 1'b0;
        step();
        chk("end_field", field, 0);
        chk("end_tick", bit_tick, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
